// File: rtl/smc_ahb_fill_master_pkg.sv
// Shared AHB-Lite encodings and fill-master state codes for the SMC fill master.
package smc_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE     = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
   localparam logic [1:0] HRESP_OKAY      = 2'b00;
   localparam logic [1:0] HRESP_ERROR     = 2'b01;
   localparam logic [2:0] HSIZE_WORD      = 3'b010;
   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

   // Fill-master FSM state codes.
   typedef logic [1:0] fm_state_t;
   localparam fm_state_t ST_IDLE = 2'd0;  // waiting for a start
   localparam fm_state_t ST_ADDR = 2'd1;  // first address phase, no data phase yet
   localparam fm_state_t ST_PIPE = 2'd2;  // address i+1 overlapped with data i
   localparam fm_state_t ST_LAST = 2'd3;  // final data phase only

   // Address-phase signal group, registered as one unit so the bus sees a coherent set.
   typedef struct packed {
      logic [31:0] haddr;
      logic [1:0]  htrans;
      logic        hwrite;
      logic [2:0]  hsize;
      logic [3:0]  hprot;
      logic        hsel;
   } ahb_addr_t;

   localparam ahb_addr_t AHB_ADDR_IDLE = '0;

   // Builds an active single-word NONSEQ address phase.
   function automatic ahb_addr_t addr_phase(input logic [31:0] addr, input logic write);
      ahb_addr_t ap;
      ap.haddr  = addr;
      ap.htrans = HTRANS_NONSEQ;
      ap.hwrite = write;
      ap.hsize  = HSIZE_WORD;
      ap.hprot  = HPROT_DATA_PRIV;
      ap.hsel   = 1'b1;
      return ap;
   endfunction

endpackage

// File: rtl/smc_ahb_fill_master.sv
// AHB-Lite initiator that fills (write) or verifies (read/compare) a contiguous
// word region with the pattern seed + beat index, using pipelined NONSEQ singles.
module smc_ahb_fill_master
   import smc_ahb_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             pmu_smc_hclk,
   input  logic             pmu_smc_hrst_b,
   input  logic             cfg_start,
   input  logic             cfg_mode,
   input  logic [31:0]      cfg_base,
   input  logic [CNT_W-1:0] cfg_count,
   input  logic [31:0]      cfg_pattern,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [31:0]      err_addr,
   output logic [31:0]      m_haddr,
   output logic [1:0]       m_htrans,
   output logic             m_hwrite,
   output logic [2:0]       m_hsize,
   output logic [3:0]       m_hprot,
   output logic             m_hsel,
   output logic [31:0]      m_hwdata,
   input  logic [31:0]      m_hrdata,
   input  logic             m_hready,
   input  logic [1:0]       m_hresp
);

   fm_state_t        state;
   ahb_addr_t        ap_q;       // registered address phase driven onto the bus
   logic             mode_q;     // 0 = write fill, 1 = read compare
   logic [31:0]      pattern_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] a_idx;      // beat index currently in address phase
   logic [CNT_W-1:0] dp_idx;     // beat index currently in data phase
   logic [31:0]      dp_addr;    // address of the beat in data phase
   logic             drop_q;     // data phase in flight is to be ignored

   logic             a_last;
   logic             resp_err;
   logic             rd_bad;
   logic [31:0]      dp_expect;
   logic             unused_base_lsb;

   // Byte offset within the word is ignored; transfers are always word aligned.
   assign unused_base_lsb = &{1'b0, cfg_base[1:0]};

   assign a_last    = (a_idx == count_q - CNT_W'(1));
   assign resp_err  = !m_hready && (m_hresp == HRESP_ERROR);
   assign dp_expect = pattern_q + 32'(dp_idx);
   assign rd_bad    = mode_q && m_hready && (m_hresp == HRESP_OKAY) && !drop_q
                      && (m_hrdata != dp_expect);

   assign m_haddr  = ap_q.haddr;
   assign m_htrans = ap_q.htrans;
   assign m_hwrite = ap_q.hwrite;
   assign m_hsize  = ap_q.hsize;
   assign m_hprot  = ap_q.hprot;
   assign m_hsel   = ap_q.hsel;

   // Job sequencing: start capture, address/data pipelining, error capture and completion.
   always_ff @(posedge pmu_smc_hclk or negedge pmu_smc_hrst_b) begin
      // NOTE: every register here uses <= so all state updates see pre-edge values,
      // which is what makes the address/data phase overlap come out right.
      if (!pmu_smc_hrst_b) begin
         state     <= ST_IDLE;
         ap_q      <= AHB_ADDR_IDLE;
         m_hwdata  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_addr  <= '0;
         mode_q    <= 1'b0;
         pattern_q <= '0;
         count_q   <= '0;
         a_idx     <= '0;
         dp_idx    <= '0;
         dp_addr   <= '0;
         drop_q    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cfg_start) begin
                  mode_q    <= cfg_mode;
                  pattern_q <= cfg_pattern;
                  count_q   <= cfg_count;
                  a_idx     <= '0;
                  err       <= 1'b0;
                  err_addr  <= '0;
                  if (cfg_count == '0) begin
                     done <= 1'b1;
                  end else begin
                     busy  <= 1'b1;
                     state <= ST_ADDR;
                     ap_q  <= addr_phase({cfg_base[31:2], 2'b00}, !cfg_mode);
                  end
               end
            end

            ST_ADDR: begin
               if (m_hready) begin
                  dp_idx  <= a_idx;
                  dp_addr <= ap_q.haddr;
                  drop_q  <= 1'b0;
                  if (!mode_q) m_hwdata <= pattern_q + 32'(a_idx);
                  if (a_last) begin
                     state <= ST_LAST;
                     ap_q  <= AHB_ADDR_IDLE;
                  end else begin
                     state      <= ST_PIPE;
                     ap_q.haddr <= ap_q.haddr + 32'd4;
                     a_idx      <= a_idx + CNT_W'(1);
                  end
               end
            end

            ST_PIPE: begin
               if (resp_err) begin
                  // First ERROR cycle: withdraw the pending address, finish the faulting beat.
                  if (!err) begin
                     err      <= 1'b1;
                     err_addr <= dp_addr;
                  end
                  state  <= ST_LAST;
                  ap_q   <= AHB_ADDR_IDLE;
                  drop_q <= 1'b1;
               end else if (m_hready) begin
                  if (rd_bad && !err) begin
                     err      <= 1'b1;
                     err_addr <= dp_addr;
                  end
                  dp_idx  <= a_idx;
                  dp_addr <= ap_q.haddr;
                  if (!mode_q) m_hwdata <= pattern_q + 32'(a_idx);
                  if (rd_bad || a_last) begin
                     // A compare failure lets the already accepted beat drain unchecked.
                     state  <= ST_LAST;
                     ap_q   <= AHB_ADDR_IDLE;
                     drop_q <= rd_bad;
                  end else begin
                     ap_q.haddr <= ap_q.haddr + 32'd4;
                     a_idx      <= a_idx + CNT_W'(1);
                  end
               end
            end

            ST_LAST: begin
               if (resp_err) begin
                  if (!err) begin
                     err      <= 1'b1;
                     err_addr <= dp_addr;
                  end
               end else if (m_hready) begin
                  if (rd_bad && !err) begin
                     err      <= 1'b1;
                     err_addr <= dp_addr;
                  end
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  m_hwdata <= '0;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
